// File: rtl/led_sched_pkg.sv
// LED pattern scheduler shared types: command modes, FSM states, field widths.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package led_sched_pkg;

    localparam int DIV_SEL_W = 5;
    localparam int MODE_W    = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_ROTATE,
        S_BOUNCE_UP,
        S_BOUNCE_DN,
        S_BLINK_ON,
        S_BLINK_OFF
    } state_e;

    // Entry state for a freshly applied command.
    function automatic state_e first_state(input mode_e m);
        case (m)
            MODE_ROTATE: return S_ROTATE;
            MODE_BOUNCE: return S_BOUNCE_UP;
            MODE_BLINK:  return S_BLINK_ON;
            default:     return S_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sched_if.sv
// Command channel of the LED pattern scheduler: {mode, div_sel[, bright]} over valid/ready.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_ready from the scheduler; a command is taken only when valid && ready.
// Build option: LED_PATTERN_SCHED_PWM_EN adds cmd_bright.
// Ports: cmd_valid, cmd_ready, cmd_mode[1:0], cmd_div_sel[4:0], cmd_bright[3:0] (PWM build only).
interface led_pattern_sched_if;
    import led_sched_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [MODE_W-1:0]    cmd_mode;
    logic [DIV_SEL_W-1:0] cmd_div_sel;
`ifdef LED_PATTERN_SCHED_PWM_EN
    logic [3:0]           cmd_bright;

    modport master (output cmd_valid, cmd_mode, cmd_div_sel, cmd_bright, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_div_sel, cmd_bright, output cmd_ready);
`else
    modport master (output cmd_valid, cmd_mode, cmd_div_sel, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_div_sel, output cmd_ready);
`endif

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: free-running counter, tick when the low div_sel bits are all ones.
// Latency: tick/heartbeat are combinational from the counter register; clr takes effect next cycle.
// Backpressure: none; free-running.
// Ports: clk, rst_n, clr (sync clear to 0), div_sel[4:0], tick, heartbeat (counter MSB).
module led_tick_gen
    import led_sched_pkg::*;
#(
    parameter int TICK_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [DIV_SEL_W-1:0] div_sel,
    output logic                 tick,
    output logic                 heartbeat
);

    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Mask of the low div_sel bits. The loop only spans TICK_W bits, so any
    // div_sel >= TICK_W saturates to an all-ones mask: that is the clamp.
    always_comb begin
        mask = '0;
        for (int i = 0; i < TICK_W; i++) begin
            mask[i] = (i < int'(div_sel));
        end
    end

    // div_sel = 0 gives an empty mask, so tick is high every cycle.
    assign tick      = ((cnt & mask) == mask);
    assign heartbeat = cnt[TICK_W-1];

endmodule

// File: rtl/led_pattern_sched.sv
// Command-driven LED pattern scheduler (OFF/ROTATE/BOUNCE/BLINK), commands applied on step boundaries.
// Latency: command applies 1 cycle after accept from OFF, else at the first later tick; leds lag state by 1 cycle.
// Backpressure: single pending slot; cmd_ready is low while a command waits to apply.
// Build option: LED_PATTERN_SCHED_PWM_EN adds per-command brightness via a 4-bit PWM gate.
// Ports: clk, rst_n, cmd (slave command channel), leds[NUM_LEDS], heartbeat, step_pos.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int NUM_LEDS        = 4,
    parameter int TICK_W          = 24,
    parameter int DEFAULT_DIV_SEL = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    led_pattern_sched_if.slave          cmd,
    output logic [NUM_LEDS-1:0]         leds,
    output logic                        heartbeat,
    output logic [$clog2(NUM_LEDS)-1:0] step_pos
);

    localparam int                POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]  LAST  = POS_W'(NUM_LEDS - 1);

    state_e               state;
    logic [POS_W-1:0]     pos;
    logic                 pend_vld;
    mode_e                pend_mode;
    logic [DIV_SEL_W-1:0] pend_div;
    logic [DIV_SEL_W-1:0] div_q;

    logic                 tick;
    logic                 accept;
    logic                 apply;
    logic                 lit_en;
    logic [NUM_LEDS-1:0]  pattern;

    assign cmd.cmd_ready = !pend_vld;
    assign accept        = cmd.cmd_valid && !pend_vld;
    // OFF has no step boundary to protect, so the command goes in immediately.
    assign apply         = pend_vld && ((state == S_OFF) || tick);

    led_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (apply),
        .div_sel   (div_q),
        .tick      (tick),
        .heartbeat (heartbeat)
    );

`ifdef LED_PATTERN_SCHED_PWM_EN
    logic [3:0] pwm_cnt;
    logic [3:0] bright_q;
    logic [3:0] pend_bright;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            bright_q    <= 4'd15;
            pend_bright <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (accept) pend_bright <= cmd.cmd_bright;
            if (apply)  bright_q    <= pend_bright;
        end
    end

    assign lit_en = (pwm_cnt < bright_q);
`else
    assign lit_en = 1'b1;
`endif

    always_comb begin
        pattern = '0;
        case (state)
            S_ROTATE, S_BOUNCE_UP, S_BOUNCE_DN: pattern[pos] = 1'b1;
            S_BLINK_ON:                         pattern      = '1;
            default:                            pattern      = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            pos       <= '0;
            pend_vld  <= 1'b0;
            pend_mode <= MODE_OFF;
            pend_div  <= '0;
            div_q     <= DIV_SEL_W'(DEFAULT_DIV_SEL);
            leds      <= '0;
            step_pos  <= '0;
        end else begin
            // Outputs reflect the state/pos held before this edge.
            leds     <= pattern & {NUM_LEDS{lit_en}};
            step_pos <= pos;

            if (accept) begin
                pend_vld  <= 1'b1;
                pend_mode <= mode_e'(cmd.cmd_mode);
                pend_div  <= cmd.cmd_div_sel;
            end

            if (apply) begin
                pend_vld <= 1'b0;
                div_q    <= pend_div;
                pos      <= '0;
                state    <= first_state(pend_mode);
            end else if (tick) begin
                case (state)
                    S_ROTATE: begin
                        pos <= (pos == LAST) ? '0 : pos + POS_W'(1);
                    end
                    S_BOUNCE_UP: begin
                        if (pos == LAST) begin
                            state <= S_BOUNCE_DN;
                            pos   <= LAST - POS_W'(1);
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                    S_BOUNCE_DN: begin
                        if (pos == '0) begin
                            state <= S_BOUNCE_UP;
                            pos   <= POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                    S_BLINK_ON:  state <= S_BLINK_OFF;
                    S_BLINK_OFF: state <= S_BLINK_ON;
                    default:     state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Testbench for led_pattern_sched (NUM_LEDS=4, TICK_W=8): directed scenarios plus randomized
// commands checked against a step-count reference model.
// Default build (no PWM).
module tb_led_pattern_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] leds;
    logic       heartbeat;
    logic [1:0] step_pos;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_sched_if cmd_if();

    led_pattern_sched #(
        .NUM_LEDS        (4),
        .TICK_W          (8),
        .DEFAULT_DIV_SEL (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .leds      (leds),
        .heartbeat (heartbeat),
        .step_pos  (step_pos)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pattern is derived from k = number of steps taken since the last apply.
    int         m_cnt, m_div, m_mode, m_k, m_pmode, m_pdiv, m_pos_out;
    bit         m_pend;
    logic [3:0] m_leds;

    function automatic int period(input int d);
        return 1 << ((d > 8) ? 8 : d);
    endfunction

    function automatic int pat_pos(input int mode, input int k);
        int m;
        if (mode == 1) return k % 4;
        if (mode == 2) begin
            m = k % 6;          // triangle wave 0,1,2,3,2,1
            return (m < 4) ? m : 6 - m;
        end
        return 0;
    endfunction

    function automatic logic [3:0] pat_leds(input int mode, input int k);
        if (mode == 1 || mode == 2) return 4'(1 << pat_pos(mode, k));
        if (mode == 3) return (k % 2 == 0) ? 4'hF : 4'h0;
        return 4'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_div = 23; m_mode = 0; m_k = 0;
            m_pend = 0; m_pmode = 0; m_pdiv = 0;
            m_leds = 4'h0; m_pos_out = 0;
        end else begin
            int  p;
            bit  tk, acc;
            p   = period(m_div);
            tk  = ((m_cnt % p) == p - 1);
            acc = cmd_if.cmd_valid && !m_pend;
            m_leds    = pat_leds(m_mode, m_k);
            m_pos_out = pat_pos(m_mode, m_k);
            if (m_pend && (m_mode == 0 || tk)) begin
                m_mode = m_pmode; m_div = m_pdiv; m_k = 0; m_cnt = 0; m_pend = 0;
            end else begin
                if (tk && m_mode != 0) m_k++;
                m_cnt = (m_cnt + 1) % 256;
            end
            if (acc) begin
                m_pend = 1; m_pmode = int'(cmd_if.cmd_mode); m_pdiv = int'(cmd_if.cmd_div_sel);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_mode    = 2'd0;
        cmd_if.cmd_div_sel = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] mode, input logic [4:0] div);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_mode    = mode;
        cmd_if.cmd_div_sel = div;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL reset_leds got=%b exp=0000", leds); end
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_if.cmd_ready); end
        n_tests++; if (step_pos !== 2'd0) begin n_fail++; $display("FAIL reset_pos got=%0d exp=0", step_pos); end
        n_tests++; if (heartbeat !== 1'b0) begin n_fail++; $display("FAIL reset_hb got=%b exp=0", heartbeat); end
        for (int k = 1; k <= 300; k++) begin
            logic exp_hb;
            step();
            exp_hb = ((k % 256) >= 128);
            n_tests++; if (heartbeat !== exp_hb) begin n_fail++; $display("FAIL idle_hb cyc=%0d got=%b exp=%b", k, heartbeat, exp_hb); end
            n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL idle_leds cyc=%0d got=%b exp=0000", k, leds); end
        end
    endtask

    task automatic test_rotate();
        do_reset();
        send(2'd1, 5'd2);
        step();                                 // E0: accept
        cmd_if.cmd_valid = 1'b0;
        n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rot_ready_pend got=%b exp=0", cmd_if.cmd_ready); end
        step();                                 // E1: apply
        n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL rot_leds_e1 got=%b exp=0000", leds); end
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rot_ready_e1 got=%b exp=1", cmd_if.cmd_ready); end
        for (int j = 2; j <= 21; j++) begin
            int         idx;
            logic [3:0] exp;
            step();
            idx = ((j - 2) / 4) % 4;
            exp = 4'(1 << idx);
            n_tests++; if (leds !== exp) begin n_fail++; $display("FAIL rot_leds e=%0d got=%b exp=%b", j, leds, exp); end
            n_tests++; if (step_pos !== 2'(idx)) begin n_fail++; $display("FAIL rot_pos e=%0d got=%0d exp=%0d", j, step_pos, idx); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        send(2'd2, 5'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++; if (leds !== seq[i]) begin n_fail++; $display("FAIL bounce_leds i=%0d got=%b exp=%b", i, leds, seq[i]); end
        end
    endtask

    task automatic test_blink_on_tick();
        do_reset();
        send(2'd1, 5'd3);
        step();                                 // E0 accept ROTATE
        cmd_if.cmd_valid = 1'b0;
        for (int e = 1; e <= 8; e++) step();    // after E8; tick sampled at E9
        send(2'd3, 5'd1);
        step();                                 // E9: accept on a tick edge
        cmd_if.cmd_valid = 1'b0;
        n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL blk_ready_e9 got=%b exp=0", cmd_if.cmd_ready); end
        n_tests++; if (leds !== 4'b0001) begin n_fail++; $display("FAIL blk_leds_e9 got=%b exp=0001", leds); end
        for (int e = 10; e <= 16; e++) begin
            step();
            n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL blk_ready e=%0d got=%b exp=0", e, cmd_if.cmd_ready); end
            n_tests++; if (leds !== 4'b0010) begin n_fail++; $display("FAIL blk_hold e=%0d got=%b exp=0010", e, leds); end
        end
        step();                                 // E17: apply BLINK
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL blk_ready_e17 got=%b exp=1", cmd_if.cmd_ready); end
        n_tests++; if (leds !== 4'b0010) begin n_fail++; $display("FAIL blk_leds_e17 got=%b exp=0010", leds); end
        for (int e = 18; e <= 25; e++) begin
            logic [3:0] exp;
            step();
            exp = (((e - 18) / 2) % 2 == 0) ? 4'hF : 4'h0;
            n_tests++; if (leds !== exp) begin n_fail++; $display("FAIL blk_leds e=%0d got=%b exp=%b", e, leds, exp); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(2'd1, 5'd2);
        step();                                 // E0 accept ROTATE
        cmd_if.cmd_valid = 1'b0;
        step();                                 // E1 apply ROTATE
        send(2'd3, 5'd2);
        step();                                 // E2 accept BLINK
        send(2'd2, 5'd1);                       // second command held valid
        for (int e = 3; e <= 4; e++) begin
            step();
            n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready e=%0d got=%b exp=0", e, cmd_if.cmd_ready); end
        end
        step();                                 // E5 apply BLINK, BOUNCE refused
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_e5 got=%b exp=1", cmd_if.cmd_ready); end
        step();                                 // E6 accept BOUNCE
        cmd_if.cmd_valid = 1'b0;
        n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_e6 got=%b exp=0", cmd_if.cmd_ready); end
        n_tests++; if (leds !== 4'hF) begin n_fail++; $display("FAIL b2b_leds_e6 got=%b exp=1111", leds); end
        step(); step();                         // E8
        n_tests++; if (leds !== 4'hF) begin n_fail++; $display("FAIL b2b_leds_e8 got=%b exp=1111", leds); end
        step();                                 // E9 apply BOUNCE
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_e9 got=%b exp=1", cmd_if.cmd_ready); end
        step();                                 // E10
        n_tests++; if (leds !== 4'b0001) begin n_fail++; $display("FAIL b2b_leds_e10 got=%b exp=0001", leds); end
        step(); step();                         // E12
        n_tests++; if (leds !== 4'b0010) begin n_fail++; $display("FAIL b2b_leds_e12 got=%b exp=0010", leds); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(2'd2, 5'd3);
        step();                                 // E0
        cmd_if.cmd_valid = 1'b0;
        for (int e = 1; e <= 20; e++) step();   // after E20: pos 2
        n_tests++; if (leds !== 4'b0100) begin n_fail++; $display("FAIL rm_pre_leds got=%b exp=0100", leds); end
        n_tests++; if (step_pos !== 2'd2) begin n_fail++; $display("FAIL rm_pre_pos got=%0d exp=2", step_pos); end
        send(2'd1, 5'd0);
        step();                                 // E21 accept, now pending
        cmd_if.cmd_valid = 1'b0;
        n_tests++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pend got=%b exp=0", cmd_if.cmd_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL rm_async_leds got=%b exp=0000", leds); end
        n_tests++; if (step_pos !== 2'd0) begin n_fail++; $display("FAIL rm_async_pos got=%0d exp=0", step_pos); end
        n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_async_ready got=%b exp=1", cmd_if.cmd_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL rm_post_leds i=%0d got=%b exp=0000", i, leds); end
            n_tests++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_post_ready i=%0d got=%b exp=1", i, cmd_if.cmd_ready); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            n_tests++; if (leds !== m_leds) begin n_fail++; $display("FAIL rnd_leds c=%0d got=%b exp=%b", c, leds, m_leds); end
            n_tests++; if (step_pos !== 2'(m_pos_out)) begin n_fail++; $display("FAIL rnd_pos c=%0d got=%0d exp=%0d", c, step_pos, m_pos_out); end
            n_tests++; if (cmd_if.cmd_ready !== !m_pend) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, cmd_if.cmd_ready, !m_pend); end
            n_tests++; if (heartbeat !== 1'((m_cnt >> 7) & 1)) begin n_fail++; $display("FAIL rnd_hb c=%0d got=%b exp=%0d", c, heartbeat, (m_cnt >> 7) & 1); end
            cmd_if.cmd_valid   = ($urandom_range(0, 5) == 0);
            cmd_if.cmd_mode    = 2'($urandom_range(0, 3));
            cmd_if.cmd_div_sel = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
            step();
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_mode    = 2'd0;
        cmd_if.cmd_div_sel = 5'd0;
        test_reset();
        test_rotate();
        test_bounce();
        test_blink_on_tick();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
